// File: rtl/serial_subtractor_n_bit_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_n_bit_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_n_bit_if.sv
// Start/busy/done operand and result bundle for the serial subtractor.
interface serial_subtractor_n_bit_if #(
  parameter int unsigned WIDTH = serial_subtractor_n_bit_pkg::DefaultWidth
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             ovf;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, ovf
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, ovf
  );
endinterface

// File: rtl/serial_subtractor_n_bit_full_subtractor_1_bit.sv
// Single-bit full subtractor cell: d = a - b - bin.
module full_subtractor_1_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor_n_bit.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock through a single cell.
module serial_subtractor_n_bit
  import serial_subtractor_n_bit_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                     clk,
  input  logic                     rst,
  serial_subtractor_n_bit_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             bout_q, bout_d, ovf_q, ovf_d;
  logic             cell_d, cell_bout;

  full_subtractor_1_bit u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d      = bus.A;
          b_d      = bus.B;
          borrow_d = bus.Bin;
          a_msb_d  = bus.A[WIDTH-1];
          b_msb_d  = bus.B[WIDTH-1];
          cnt_d    = '0;
          state_d  = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        r_d      = {cell_d, r_q[WIDTH-1:1]};
        borrow_d = cell_bout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          d_d     = r_d;
          bout_d  = cell_bout;
          // cell_d is the result MSB on the final bit
          ovf_d   = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy = (state_q == StShift);
  assign bus.done = (state_q == StDone);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor_n_bit.sv
// Directed-vector bench for the bit-serial subtractor at WIDTH = 4.
module tb_serial_subtractor_n_bit;
  import serial_subtractor_n_bit_pkg::*;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  serial_subtractor_n_bit_if #(.WIDTH(W)) bus ();

  serial_subtractor_n_bit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] ed, input logic eb, input logic eo);
    check({tag, ".D"},    32'(bus.D),    32'(ed));
    check({tag, ".Bout"}, 32'(bus.Bout), 32'(eb));
    check({tag, ".ovf"},  32'(bus.ovf),  32'(eo));
  endtask

  // Issue one operation and check timing plus results at the done cycle.
  task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic bi, input logic [3:0] ed, input logic eb, input logic eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bi;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    repeat (3) @(posedge clk);
    #1 check({tag, ".early_done"}, 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    check({tag, ".done"}, 32'(bus.done), 32'd1);
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_outs(tag, ed, eb, eo);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
    check_outs({tag, ".hold"}, ed, eb, eo);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Bin   = 1'b0;
    #12;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_outs("rst", 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // ovf follows the formula: mixed-sign operands whose result sign differs from A
    do_op("9m3",   4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);
    do_op("3m9",   4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1);
    do_op("0m0b1", 4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0);
    do_op("7m8",   4'h7, 4'h8, 1'b0, 4'hF, 1'b1, 1'b1);
    do_op("8m1",   4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1);
    do_op("5m2b1", 4'h5, 4'h2, 1'b1, 4'h2, 1'b0, 1'b0);
    do_op("FmFb1", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

    // Start during SHIFT is ignored; start held into DONE chains with no idle cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'h5; bus.B = 4'h2; bus.Bin = 1'b0;
    @(posedge clk); #1;                       // edge k
    bus.start = 1'b0;
    @(posedge clk); #1;                       // k+1
    bus.start = 1'b1; bus.A = 4'hF; bus.B = 4'h0; bus.Bin = 1'b1;
    @(posedge clk); #1;                       // k+2, start seen in SHIFT
    bus.start = 1'b0;
    check("ign.busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;                       // k+3
    bus.start = 1'b1; bus.A = 4'hC; bus.B = 4'h3; bus.Bin = 1'b1;
    @(posedge clk); #1;                       // k+4
    check("ign.done", 32'(bus.done), 32'd1);
    check_outs("ign", 4'h3, 1'b0, 1'b0);
    @(posedge clk); #1;                       // k+5, accepted from DONE
    bus.start = 1'b0;
    check("b2b.busy", 32'(bus.busy), 32'd1);
    check("b2b.done", 32'(bus.done), 32'd0);
    check_outs("b2b.hold", 4'h3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 check("b2b.early_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;                       // k+9
    check("b2b.done2", 32'(bus.done), 32'd1);
    check_outs("b2b", 4'h8, 1'b0, 1'b0);

    // Asynchronous reset mid-SHIFT clears everything before the next edge.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 4'h9; bus.B = 4'h3; bus.Bin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst.busy", 32'(bus.busy), 32'd0);
    check("arst.done", 32'(bus.done), 32'd0);
    check_outs("arst", 4'h0, 1'b0, 1'b0);
    check("arst.state", 32'(dut.state_q), 32'(StIdle));
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst", 4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
